// File: rtl/aes128_iter_core.sv
// rtl/aes128_iter_core.sv - iterative AES-128 encryptor, ROUNDS_PER_CYCLE rounds per clock
// Optional completed-block counter port blk_cnt when AES_CNT_EN is defined.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;

  // Multiplicative inverse as a^254 (square-and-multiply over 8'b1111_1110); 0 maps to 0.
  always_comb begin
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gmul(inv, inv);
      if (i != 0) inv = gmul(inv, a);
    end
  end

  assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_round (
  input  logic [127:0] state,
  input  logic [127:0] rkey,
  input  logic         is_last,
  output logic [127:0] result
);
  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  logic [127:0] sb, sr, mc;

  for (genvar g = 0; g < 16; g++) begin : g_sb
    aes_sbox u_sbox (.a(state[g*8 +: 8]), .y(sb[g*8 +: 8]));
  end

  // Byte 4c+r is row r of column c; row r rotates left by r columns.
  always_comb begin
    sr = '0;
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[(4*c + r)*8 +: 8] = sb[(4*((c + r) % 4) + r)*8 +: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        mc[(4*c + r)*8 +: 8] = xt(sr[(4*c + r)*8 +: 8])
                             ^ xt(sr[(4*c + (r + 1) % 4)*8 +: 8]) ^ sr[(4*c + (r + 1) % 4)*8 +: 8]
                             ^ sr[(4*c + (r + 2) % 4)*8 +: 8] ^ sr[(4*c + (r + 3) % 4)*8 +: 8];
      end
    end
  end

  assign result = (is_last ? sr : mc) ^ rkey;
endmodule

module aes_key_step (
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key,
  output logic [7:0]   next_rcon
);
  logic [31:0] rot, sub, t, w0, w1, w2, w3;

  assign rot = {key[103:96], key[127:120], key[119:112], key[111:104]};

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (.a(rot[g*8 +: 8]), .y(sub[g*8 +: 8]));
  end

  assign t         = sub ^ {24'b0, rcon};
  assign w0        = key[31:0] ^ t;
  assign w1        = key[63:32] ^ w0;
  assign w2        = key[95:64] ^ w1;
  assign w3        = key[127:96] ^ w2;
  assign next_key  = {w3, w2, w1, w0};
  assign next_rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
endmodule

module aes128_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block
`ifdef AES_CNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);
  localparam int NCYC = 10 / ROUNDS_PER_CYCLE;
  localparam logic [3:0] RSTEP = 4'(ROUNDS_PER_CYCLE);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_cfg
    $error("ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_n;
  logic [127:0] state_reg, key_reg;
  logic [7:0]   rcon;
  logic [3:0]   rnd;
  logic         accept, run_last;

  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : stg
    logic [127:0] s_in, k_in, s_out, k_out;
    logic [7:0]   r_in, r_out;
    logic         last;
    if (j == 0) begin : g_head
      assign s_in = state_reg;
      assign k_in = key_reg;
      assign r_in = rcon;
    end else begin : g_link
      assign s_in = stg[j-1].s_out;
      assign k_in = stg[j-1].k_out;
      assign r_in = stg[j-1].r_out;
    end
    assign last = ({1'b0, rnd} + 5'(j + 1)) == 5'd10;
    aes_key_step u_ks (.key(k_in), .rcon(r_in), .next_key(k_out), .next_rcon(r_out));
    aes_round    u_rd (.state(s_in), .rkey(k_out), .is_last(last), .result(s_out));
  end

  assign run_last = (rnd + RSTEP) == 4'd10;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        if (run_last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_n = in_valid ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
      key_reg   <= '0;
      rcon      <= '0;
      rnd       <= '0;
      out_block <= '0;
    end else if (accept) begin
      state_reg <= in_block ^ in_key;
      key_reg   <= in_key;
      rcon      <= 8'h01;
      rnd       <= '0;
    end else if (state == RUN) begin
      state_reg <= stg[ROUNDS_PER_CYCLE-1].s_out;
      key_reg   <= stg[ROUNDS_PER_CYCLE-1].k_out;
      rcon      <= stg[ROUNDS_PER_CYCLE-1].r_out;
      rnd       <= rnd + RSTEP;
      if (run_last) out_block <= stg[ROUNDS_PER_CYCLE-1].s_out;
    end
  end

`ifdef AES_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      blk_cnt <= '0;
    else if (out_valid && out_ready && blk_cnt != 32'hFFFF_FFFF)
      blk_cnt <= blk_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_aes128_iter_core.sv
// tb/tb_aes128_iter_core.sv - directed and randomized checks of aes128_iter_core
// Exercises blk_cnt when AES_CNT_EN is defined.

module tb_aes128_iter_core;
  parameter int R = 1;
  localparam int NCYC = 10 / R;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid;
  logic [127:0] in_block = '0, in_key = '0, out_block;
`ifdef AES_CNT_EN
  logic [31:0]  blk_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sbox_t [256];

  aes128_iter_core #(.ROUNDS_PER_CYCLE(R)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_key(in_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block)
`ifdef AES_CNT_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from log/antilog tables over generator 3, then the FIPS affine map.
  task automatic init_sbox();
    logic [7:0] ex [256];
    int lg [256];
    logic [7:0] p, b, s, c;
    c = 8'h63;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = i;
      p = p ^ xt(p);
    end
    for (int x = 0; x < 256; x++) begin
      b = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [127:0] fips(input logic [127:0] h);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = h[127 - 8*i -: 8];
    return r;
  endfunction

  function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] w [176];
    logic [7:0] st [16];
    logic [7:0] tmp [16];
    logic [7:0] tw [4];
    logic [7:0] rc;
    logic [127:0] ct;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      w[i]  = key[8*i +: 8];
      st[i] = pt[8*i +: 8];
    end
    for (int i = 16; i < 176; i += 4) begin
      for (int k = 0; k < 4; k++) tw[k] = w[i-4+k];
      if (i % 16 == 0) begin
        tw[0] = sbox_t[w[i-3]] ^ rc;
        tw[1] = sbox_t[w[i-2]];
        tw[2] = sbox_t[w[i-1]];
        tw[3] = sbox_t[w[i-4]];
        rc = xt(rc);
      end
      for (int k = 0; k < 4; k++) w[i+k] = w[i-16+k] ^ tw[k];
    end
    for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[i];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) tmp[i] = sbox_t[st[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) st[4*c+r] = tmp[4*((c+r)%4)+r];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) tw[r] = st[4*c+r];
          st[4*c+0] = xt(tw[0]) ^ xt(tw[1]) ^ tw[1] ^ tw[2] ^ tw[3];
          st[4*c+1] = tw[0] ^ xt(tw[1]) ^ xt(tw[2]) ^ tw[2] ^ tw[3];
          st[4*c+2] = tw[0] ^ tw[1] ^ xt(tw[2]) ^ xt(tw[3]) ^ tw[3];
          st[4*c+3] = xt(tw[0]) ^ tw[0] ^ tw[1] ^ tw[2] ^ xt(tw[3]);
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[16*rd + i];
    end
    for (int i = 0; i < 16; i++) ct[8*i +: 8] = st[i];
    return ct;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic accept_block(input logic [127:0] pt, input logic [127:0] key);
    int w;
    in_block = pt;
    in_key   = key;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    check("accept_wait", {127'b0, in_ready}, 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_block = rnd128();
    in_key   = rnd128();
  endtask

  task automatic wait_out(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check(tag, 128'(lat), 128'(NCYC));
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] key, output logic [127:0] ct);
    out_ready = 1'b0;
    accept_block(pt, key);
    wait_out("latency");
    ct = out_block;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drop_after_hs", {127'b0, out_valid}, 128'd0);
  endtask

  logic [127:0] v1_k, v1_p, v1_c, v2_k, v2_p, v2_c, ct, pt, key, exp;
  logic [127:0] expq [$];
  int sent, got, last_t, cyc, hs, stray, k;
  logic acc;

  initial begin
    init_sbox();
    v1_k = 128'h000102030405060708090a0b0c0d0e0f;
    v1_p = 128'h00112233445566778899aabbccddeeff;
    v1_c = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    v2_k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    v2_p = 128'h3243f6a8885a308d313198a2e0370734;
    v2_c = 128'h3925841d02dc09fbdc118597196a0b32;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {127'b0, in_ready}, 128'd0);
    check("rst_out_valid", {127'b0, out_valid}, 128'd0);
    check("rst_out_block", out_block, 128'd0);
`ifdef AES_CNT_EN
    check("rst_blk_cnt", 128'(blk_cnt), 128'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", {127'b0, in_ready}, 128'd1);

    run_block(fips(v1_p), fips(v1_k), ct);
    check("fips_c1", ct, fips(v1_c));
    run_block(fips(v2_p), fips(v2_k), ct);
    check("fips_b", ct, fips(v2_c));
`ifdef AES_CNT_EN
    check("blk_cnt_two", 128'(blk_cnt), 128'd2);
`endif

    for (int i = 0; i < 3; i++) begin
      pt = rnd128();
      key = rnd128();
      run_block(pt, key, ct);
      check("random_ct", ct, ref_aes(pt, key));
    end

    pt = rnd128();
    key = rnd128();
    exp = ref_aes(pt, key);
    out_ready = 1'b0;
    accept_block(pt, key);
    wait_out("bp_latency");
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("bp_block", out_block, exp);
      check("bp_in_ready", {127'b0, in_ready}, 128'd0);
      check("bp_out_valid", {127'b0, out_valid}, 128'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid && out_ready) hs++;
      @(posedge clk); #1;
    end
    check("bp_handshakes", 128'(hs), 128'd1);
    out_ready = 1'b0;

    out_ready = 1'b1;
    in_block = rnd128();
    in_key = rnd128();
    in_valid = 1'b1;
    sent = 0; got = 0; last_t = -1; cyc = 0;
    while (got < 8 && cyc < 400) begin
      if (out_valid) begin
        if (expq.size() == 0) check("stream_extra", out_block, 128'd0 ^ ~out_block);
        else check("stream_ct", out_block, expq.pop_front());
        if (last_t >= 0) check("stream_gap", 128'(cyc - last_t), 128'(NCYC + 1));
        last_t = cyc;
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        expq.push_back(ref_aes(in_block, in_key));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (sent < 8) begin
          in_block = rnd128();
          in_key = rnd128();
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("stream_count", 128'(got), 128'd8);
    out_ready = 1'b0;
    @(posedge clk); #1;

    accept_block(fips(v1_p), fips(v1_k));
    k = (NCYC > 4) ? 4 : NCYC - 1;
    repeat (k) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {127'b0, out_valid}, 128'd0);
    check("midrst_in_ready", {127'b0, in_ready}, 128'd0);
    check("midrst_out_block", out_block, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    stray = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) stray++;
      @(posedge clk); #1;
    end
    check("midrst_stray", 128'(stray), 128'd0);
    out_ready = 1'b0;
    run_block(fips(v1_p), fips(v1_k), ct);
    check("midrst_fips_c1", ct, fips(v1_c));

`ifdef AES_CNT_EN
    check("blk_cnt_after_rst", 128'(blk_cnt), 128'd1);
    force dut.blk_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.blk_cnt;
    for (int i = 0; i < 3; i++) begin
      pt = rnd128();
      key = rnd128();
      run_block(pt, key, ct);
      check("sat_ct", ct, ref_aes(pt, key));
      check("blk_cnt_sat", 128'(blk_cnt), 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
